// File: rtl/arc_system.sv
// Boot-message serialiser: sends "ARC\r\n" as UART 8N1 frames on tx, advancing one byte per
// host acknowledge pulse seen on rx.
module arc_system #(
    parameter int unsigned clk_freq = 50_000_000,
    parameter int unsigned baud     = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx
);

    localparam int unsigned Div       = clk_freq / baud;
    localparam int unsigned CntW      = $clog2(Div);
    localparam logic [CntW-1:0] CntReload = CntW'(Div - 1);
    localparam logic [2:0] LastIdx    = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop,
        StWaitAck,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic            tx_q, tx_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      bit_q, bit_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, sync2_q, sync_prev_q;
    logic            pending_q, pending_d;
    logic            ack_evt;
    logic            consume;
    logic            baud_tick;

    function automatic logic [7:0] msg_byte(input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = 8'h41;
            3'd1:    b = 8'h52;
            3'd2:    b = 8'h43;
            3'd3:    b = 8'h0D;
            3'd4:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign ack_evt   = sync2_q & ~sync_prev_q;
    assign baud_tick = (baud_q == '0);

    always_comb begin
        state_d = state_q;
        tx_d    = 1'b1;
        idx_d   = idx_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        consume = 1'b0;

        unique case (state_q)
            StIdle: state_d = StLoad;

            // tx is registered, so the start bit is driven while leaving LOAD
            StLoad: begin
                shift_d = msg_byte(idx_q);
                baud_d  = CntReload;
                bit_d   = 3'd0;
                tx_d    = 1'b0;
                state_d = StStart;
            end

            StStart: begin
                tx_d = 1'b0;
                if (baud_tick) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    baud_d  = CntReload;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            // shift_q[0] always holds the bit currently on the line
            StData: begin
                tx_d = shift_q[0];
                if (baud_tick) begin
                    baud_d = CntReload;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            StStop: begin
                if (baud_tick) begin
                    state_d = StWaitAck;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            StWaitAck: begin
                if (pending_q) begin
                    consume = 1'b1;
                    idx_d   = idx_q + 3'd1;
                    state_d = (idx_q == LastIdx) ? StDone : StLoad;
                end
            end

            StDone: state_d = StDone;

            default: state_d = StIdle;
        endcase
    end

    // One-deep ack latch; edges arriving while it is set are dropped
    assign pending_d = consume ? 1'b0 : (pending_q | ack_evt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            tx_q        <= 1'b1;
            idx_q       <= 3'd0;
            bit_q       <= 3'd0;
            baud_q      <= '0;
            shift_q     <= 8'h00;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            idx_q       <= idx_d;
            bit_q       <= bit_d;
            baud_q      <= baud_d;
            shift_q     <= shift_d;
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            pending_q   <= pending_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_arc_system.sv
// Randomised bench for arc_system: a frame-timeline model predicts tx every cycle.
module tb_arc_system;

    localparam int unsigned ClkFreq = 50_000_000;
    localparam int unsigned Baud    = 12_500_000;
    localparam int          Div     = ClkFreq / Baud;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b0;
    logic tx;

    int checks = 0;
    int errors = 0;

    arc_system #(
        .clk_freq(ClkFreq),
        .baud    (Baud)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .tx (tx)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: message as bytes, a frame described by its start edge, acks as events.
    logic [7:0] msg [5] = '{8'h41, 8'h52, 8'h43, 8'h0D, 8'h0A};
    longint     n = 0;
    longint     f;
    int         idx;
    bit         done, pending, valid = 0;
    bit         rx_d1, rx_d2, rx_d3;
    logic       exp_tx = 1'b1;

    always @(posedge clk) begin
        bit     evt, take;
        longint k;
        n++;
        if (!rst) begin
            rx_d1 = 0; rx_d2 = 0; rx_d3 = 0;
            pending = 0; idx = 0; done = 0;
            f = n + 2;
            exp_tx = 1'b1;
            valid = 1;
        end else begin
            // rx seen 2 edges ago rising relative to 3 edges ago
            evt  = rx_d2 & ~rx_d3;
            take = !done && pending && (n > f + 10 * Div);
            if (take) begin
                pending = 0;
                idx++;
                if (idx == 5) done = 1;
                else f = n + 1;
            end else if (evt) begin
                pending = 1;
            end
            rx_d3 = rx_d2; rx_d2 = rx_d1; rx_d1 = rx;
            exp_tx = 1'b1;
            if (!done && n >= f && n < f + 10 * Div) begin
                k = (n - f) / Div;
                if (k == 0)      exp_tx = 1'b0;
                else if (k == 9) exp_tx = 1'b1;
                else             exp_tx = msg[idx][k-1];
            end
        end
    end

    always @(negedge clk) begin
        if (valid) check($sformatf("tx@%0d", n), {31'd0, tx}, {31'd0, exp_tx});
    end

    task automatic cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic pulse(input int width, input int gap);
        rx = 1'b1;
        cycles(width);
        rx = 1'b0;
        cycles(gap);
    endtask

    task automatic do_reset(input int len);
        rst = 1'b0;
        cycles(len);
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset(4);
        cycles(60);
        // five closely spaced acks: some land mid-frame and are latched or dropped
        for (int i = 0; i < 5; i++) pulse(2, 10);
        for (int i = 0; i < 6; i++) pulse(2, 50);
        // random acks of varying width and spacing, with occasional mid-frame resets
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cycles($urandom_range(0, 45));
                do_reset($urandom_range(1, 3));
            end
            pulse($urandom_range(1, 4), $urandom_range(0, 60));
        end
        // full message, then acks in DONE must be ignored
        do_reset(2);
        for (int i = 0; i < 5; i++) pulse(2, 50);
        for (int i = 0; i < 10; i++) pulse(2, 12);
        cycles(5000);
        // reset during byte 2 restarts the message from 0x41
        do_reset(1);
        pulse(2, 50);
        pulse(2, 20);
        do_reset(1);
        cycles(60);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
